alu_sequencer: RTL and testbench

Multi-cycle control sequencer that drives the shared ALU and register-file write port from a program held in instruction memory. It fetches each instruction, decodes the 4-bit opcode, issues the opcode to the ALU, and either commits the result or resolves a conditional jump. It halts on ACK. It sits between instruction memory, the ALU and the register file, and replaces hard-wired single-cycle control when the datapath runs in stepped mode.

---
 rtl/alu_sequencer_if.sv | 31 +++
 rtl/alu_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Bus bundle between the ALU sequencer and its program memory, ALU, register file and controller.
// The master modport is the sequencer's view; slave is the surrounding datapath/controller.
interface alu_sequencer_if #(
  parameter int unsigned IW   = 9,
  parameter int unsigned PC_W = 8
);
  logic            start;
  logic [PC_W-1:0] start_addr;
  logic            hold;
  logic [PC_W-1:0] imem_addr;
  logic [IW-1:0]   imem_data;
  logic [IW-1:0]   instr;
  logic [3:0]      alu_op;
  logic            alu_en;
  logic            alu_zero;
  logic            rf_we;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            done;
  logic [15:0]     cycle_cnt;

  modport master (
    input  start, start_addr, hold, imem_data, alu_zero,
    output imem_addr, instr, alu_op, alu_en, rf_we, pc, busy, done, cycle_cnt
  );

  modport slave (
    output start, start_addr, hold, imem_data, alu_zero,
    input  imem_addr, instr, alu_op, alu_en, rf_we, pc, busy, done, cycle_cnt
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-cycle fetch/decode/exec/commit sequencer driving a shared ALU and register-file write port.
// Define ALU_SEQ_PERF_CNT_EN to build the saturating busy-cycle counter on cycle_cnt.
module alu_sequencer #(
  parameter int unsigned IW   = 9,
  parameter int unsigned PC_W = 8
) (
  input logic             clk_i,
  input logic             rst_ni,
  alu_sequencer_if.master bus
);
  localparam int unsigned OffW = IW - 4;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StCommit = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  localparam logic [3:0] OpJeq  = 4'b1010;
  localparam logic [3:0] OpJneq = 4'b1111;
  localparam logic [3:0] OpAck  = 4'b1101;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            alu_en_q, alu_en_d;
  logic            z_q, z_d;

  logic [3:0]      opcode;
  logic [PC_W-1:0] pc_inc, br_target;
  logic            writes_rf;
  logic            busy;
  logic            start_ok;

  assign opcode    = instr_q[IW-1 -: 4];
  assign pc_inc    = pc_q + PC_W'(1);
  assign br_target = pc_q + {{(PC_W-OffW){instr_q[OffW-1]}}, instr_q[OffW-1:0]};
  assign busy      = (state_q == StFetch) | (state_q == StDecode) |
                     (state_q == StExec)  | (state_q == StCommit);
  assign start_ok  = bus.start & ~bus.hold & ((state_q == StIdle) | (state_q == StDone));

  always_comb begin
    writes_rf = 1'b0;
    unique case (opcode)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b1011, 4'b1100, 4'b1110: writes_rf = 1'b1;
      default:                            writes_rf = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imem_addr_d = imem_addr_q;
    instr_d     = instr_q;
    alu_op_d    = alu_op_q;
    alu_en_d    = alu_en_q;
    z_d         = z_q;
    if (!bus.hold) begin
      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            pc_d        = bus.start_addr;
            imem_addr_d = bus.start_addr;
            state_d     = StFetch;
          end
        end
        StFetch: state_d = StDecode;
        StDecode: begin
          // Opcode comes straight from memory so alu_op is valid for all of EXEC.
          instr_d  = bus.imem_data;
          alu_op_d = bus.imem_data[IW-1 -: 4];
          alu_en_d = 1'b1;
          state_d  = StExec;
        end
        StExec: begin
          z_d      = bus.alu_zero;
          alu_en_d = 1'b0;
          state_d  = StCommit;
        end
        StCommit: begin
          state_d = StFetch;
          unique case (opcode)
            OpJeq:   pc_d = z_q ? br_target : pc_inc;
            OpJneq:  pc_d = z_q ? pc_inc : br_target;
            OpAck:   state_d = StDone;
            default: pc_d = pc_inc;
          endcase
          imem_addr_d = pc_d;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      imem_addr_q <= '0;
      instr_q     <= '0;
      alu_op_q    <= '0;
      alu_en_q    <= 1'b0;
      z_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_addr_q <= imem_addr_d;
      instr_q     <= instr_d;
      alu_op_q    <= alu_op_d;
      alu_en_q    <= alu_en_d;
      z_q         <= z_d;
    end
  end

  assign bus.imem_addr = imem_addr_q;
  assign bus.instr     = instr_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_en    = alu_en_q;
  // Level stays high through a held COMMIT; the write lands on the edge that leaves COMMIT.
  assign bus.rf_we     = (state_q == StCommit) & writes_rf;
  assign bus.pc        = pc_q;
  assign bus.busy      = busy;
  assign bus.done      = (state_q == StDone);

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (start_ok) begin
      cnt_q <= '0;
    end else if (busy && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.cycle_cnt = cnt_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign bus.cycle_cnt   = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: timing of the basic program, branches, wrap, stalls, reset.
// Register-file writes are tracked by a scoreboard of expected write PCs.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  alu_sequencer_if #(.IW(9), .PC_W(8)) bus ();

  alu_sequencer #(.IW(9), .PC_W(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  localparam logic [8:0] WAdd   = {4'b0000, 5'b10101};
  localparam logic [8:0] WXor   = {4'b0010, 5'b00110};
  localparam logic [8:0] WAck   = {4'b1101, 5'b00000};
  localparam logic [8:0] WOr    = {4'b1110, 5'b00011};
  localparam logic [8:0] WJeqM2 = {4'b1010, 5'b11110};
  localparam logic [8:0] WJnqM2 = {4'b1111, 5'b11110};
  localparam logic [8:0] WJnqM3 = {4'b1111, 5'b11101};
  localparam logic [8:0] WNop7  = {4'b0111, 5'b00000};
  localparam logic [8:0] WJeq0  = {4'b1010, 5'b00000};

  logic [8:0] imem [256];
  always @(posedge clk) bus.imem_data <= imem[bus.imem_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic [7:0] exp_q [$];
  logic we_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Actual writes: rf_we seen high on an edge that is not stalled.
  always @(posedge clk) if (rst_ni && bus.rf_we && !bus.hold) wr_cnt++;

  always @(negedge clk) begin
    if (rst_ni && bus.rf_we && !we_prev) begin
      if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else check("wr_pc", {24'd0, bus.pc}, {24'd0, exp_q.pop_front()});
    end
    we_prev = bus.rf_we;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_ack();
    for (int i = 0; i < 256; i++) imem[i] = WAck;
  endtask

  // Returns at the negedge of the first FETCH cycle (N+1).
  task automatic start_prog(input logic [7:0] addr);
    @(negedge clk);
    bus.start_addr = addr;
    bus.start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus.done}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [8:0] word;
    logic       z;
    logic [7:0] nxt;
    logic       we;
  } case_t;

  case_t cases [8];
  int    wr_base;

  initial begin
    cases[0] = '{addr: 8'd5,   word: WJeqM2, z: 1'b1, nxt: 8'd3,   we: 1'b0};
    cases[1] = '{addr: 8'd5,   word: WJeqM2, z: 1'b0, nxt: 8'd6,   we: 1'b0};
    cases[2] = '{addr: 8'd5,   word: WJnqM2, z: 1'b0, nxt: 8'd3,   we: 1'b0};
    cases[3] = '{addr: 8'd5,   word: WJnqM2, z: 1'b1, nxt: 8'd6,   we: 1'b0};
    cases[4] = '{addr: 8'd255, word: WOr,    z: 1'b0, nxt: 8'd0,   we: 1'b1};
    cases[5] = '{addr: 8'd2,   word: WJnqM3, z: 1'b0, nxt: 8'd255, we: 1'b0};
    cases[6] = '{addr: 8'd10,  word: WNop7,  z: 1'b0, nxt: 8'd11,  we: 1'b0};
    cases[7] = '{addr: 8'd20,  word: WJeq0,  z: 1'b1, nxt: 8'd20,  we: 1'b0};

    rst_ni         = 1'b0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.hold       = 1'b0;
    bus.alu_zero   = 1'b0;
    fill_ack();
    wait_n(2);
    check("rst_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
    check("rst_instr", {23'd0, bus.instr}, 32'd0);
    check("rst_alu_op", {28'd0, bus.alu_op}, 32'd0);
    check("rst_alu_en", {31'd0, bus.alu_en}, 32'd0);
    check("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    check("rst_pc", {24'd0, bus.pc}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_cycle_cnt", {16'd0, bus.cycle_cnt}, 32'd0);
    rst_ni = 1'b1;

    // Basic program: ADD, XOR, ACK.
    imem[0] = WAdd;
    imem[1] = WXor;
    imem[2] = WAck;
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    start_prog(8'd0);
    check("b_busy_n1", {31'd0, bus.busy}, 32'd1);
    check("b_imem_addr_n1", {24'd0, bus.imem_addr}, 32'd0);
    wait_n(2);
    check("b_alu_en_n3", {31'd0, bus.alu_en}, 32'd1);
    check("b_instr_n3", {23'd0, bus.instr}, {23'd0, WAdd});
    check("b_rf_we_n3", {31'd0, bus.rf_we}, 32'd0);
    wait_n(1);
    check("b_rf_we_n4", {31'd0, bus.rf_we}, 32'd1);
    wait_n(1);
    check("b_rf_we_n5", {31'd0, bus.rf_we}, 32'd0);
    wait_n(2);
    check("b_alu_op_n7", {28'd0, bus.alu_op}, 32'd2);
    wait_n(1);
    check("b_rf_we_n8", {31'd0, bus.rf_we}, 32'd1);
    wait_n(4);
    check("b_done_n12", {31'd0, bus.done}, 32'd0);
    check("b_rf_we_n12", {31'd0, bus.rf_we}, 32'd0);
    wait_n(1);
    check("b_done_n13", {31'd0, bus.done}, 32'd1);
    check("b_busy_n13", {31'd0, bus.busy}, 32'd0);
    check("b_pc_ack", {24'd0, bus.pc}, 32'd2);
`ifdef ALU_SEQ_PERF_CNT_EN
    check("b_cycle_cnt", {16'd0, bus.cycle_cnt}, 32'd12);
`else
    check("b_cycle_cnt", {16'd0, bus.cycle_cnt}, 32'd0);
`endif

    // Branches, wrap, undefined opcode, self-loop; each restarts from DONE.
    foreach (cases[i]) begin
      fill_ack();
      imem[cases[i].addr] = cases[i].word;
      bus.alu_zero = cases[i].z;
      if (cases[i].we) exp_q.push_back(cases[i].addr);
      start_prog(cases[i].addr);
      check($sformatf("c%0d_done_cleared", i), {31'd0, bus.done}, 32'd0);
      wait_n(3);
      check($sformatf("c%0d_rf_we", i), {31'd0, bus.rf_we}, {31'd0, cases[i].we});
      check($sformatf("c%0d_pc", i), {24'd0, bus.pc}, {24'd0, cases[i].addr});
      wait_n(1);
      check($sformatf("c%0d_next_addr", i), {24'd0, bus.imem_addr}, {24'd0, cases[i].nxt});
      bus.alu_zero = 1'b0;
      wait_done($sformatf("c%0d_done", i));
    end

    // Stall: hold 3 cycles in EXEC of ADD, then 2 cycles in its COMMIT.
    fill_ack();
    imem[0] = WAdd;
    exp_q.push_back(8'd0);
    wr_base = wr_cnt;
    start_prog(8'd0);
    wait_n(2);
    for (int k = 3; k <= 10; k++) begin
      if (k > 3) @(negedge clk);
      if (k == 3 || k == 7) bus.hold = 1'b1;
      if (k == 6 || k == 9) bus.hold = 1'b0;
      check($sformatf("s_alu_en_n%0d", k), {31'd0, bus.alu_en}, {31'd0, (k >= 3 && k <= 6)});
      check($sformatf("s_rf_we_n%0d", k), {31'd0, bus.rf_we}, {31'd0, (k >= 7 && k <= 9)});
    end
    wait_done("s_done");
    check("s_write_count", wr_cnt - wr_base, 32'd1);

    // Asynchronous reset in the middle of COMMIT.
    exp_q.push_back(8'd0);
    wr_base = wr_cnt;
    start_prog(8'd0);
    wait_n(3);
    check("r_rf_we_pre", {31'd0, bus.rf_we}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("r_rf_we_async", {31'd0, bus.rf_we}, 32'd0);
    check("r_busy_async", {31'd0, bus.busy}, 32'd0);
    check("r_pc_async", {24'd0, bus.pc}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    check("r_no_write", wr_cnt - wr_base, 32'd0);
    check("r_done", {31'd0, bus.done}, 32'd0);

    // start pulsed while busy must be ignored.
    imem[0] = WAdd;
    imem[1] = WXor;
    imem[2] = WAck;
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    start_prog(8'd0);
    wait_n(1);
    bus.start_addr = 8'd40;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("i_done");
    check("i_pc_ack", {24'd0, bus.pc}, 32'd2);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
